// File: rtl/dma_pkg.sv
// Shared types and constants for the DMA FIFO sequencer.
// FSM state encoding, FIFO geometry and the burst-size helper.
package dma_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        READ  = 3'd1,
        WRITE = 3'd2,
        DRAIN = 3'd3,
        DONE  = 3'd4
    } dma_state_e;

    localparam int FIFO_DEPTH  = 16;
    localparam int FIFO_USABLE = 15;
    localparam int WORD_BYTES  = 4;

    // Next burst length: the smaller of the configured burst and the words left.
    function automatic logic [3:0] burst_size(input logic [31:0] rem,
                                              input logic [3:0]  blen);
        if (rem < {28'd0, blen}) begin
            return rem[3:0];
        end else begin
            return blen;
        end
    endfunction

endpackage

// File: rtl/dma_addr_gen.sv
// Word address generator: loads a start address and steps by one word,
// wrapping modulo 2^ADDR_W. Used once for the source and once for the
// destination side.
module dma_addr_gen
    import dma_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic              inc,
    output logic [ADDR_W-1:0] addr
);

    logic [ADDR_W-1:0] addr_r;

    // Address register: load has priority over increment; increment wraps.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            addr_r <= {ADDR_W{1'b0}};
        end else if (load) begin
            addr_r <= load_addr;
        end else if (inc) begin
            addr_r <= addr_r + ADDR_W'(WORD_BYTES);
        end else begin
            addr_r <= addr_r;
        end
    end

    assign addr = addr_r;

endmodule

// File: rtl/dma_fifo_ctrl.sv
// DMA FIFO sequencer: fills the FIFO from the source port one burst at a
// time, drains each burst to the destination port, and repeats until the
// programmed word count has moved. Abort empties the FIFO without writing.
// Optional interrupt output enabled by defining DMA_FIFO_CTRL_IRQ_EN.
module dma_fifo_ctrl
    import dma_pkg::*;
#(
    parameter int ADDR_W    = 32,
    parameter int CNT_W     = 16,
    parameter int BURST_LEN = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic [ADDR_W-1:0] src_addr,
    input  logic [ADDR_W-1:0] dst_addr,
    input  logic [CNT_W-1:0]  xfer_words,
    output logic              rd_req,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic              rd_valid,
    output logic              wr_req,
    output logic [ADDR_W-1:0] wr_addr,
    input  logic              wr_ready,
    output logic              wc_en,
    output logic              rc_en,
    input  logic              full,
    input  logic              fifo_empty,
    output logic              busy,
    output logic              done,
    output logic              err
`ifdef DMA_FIFO_CTRL_IRQ_EN
    ,
    output logic              irq,
    input  logic              irq_clr
`endif
);

    localparam logic [3:0] BURST_W4 = 4'(BURST_LEN);

    dma_state_e        state_r;
    dma_state_e        state_s;
    logic [CNT_W-1:0]  remaining_r;
    logic [3:0]        burst_left_r;
    logic              err_r;
    logic              done_r;

    logic              start_ok_s;
    logic              rd_req_s;
    logic              wr_req_s;
    logic              wc_en_s;
    logic              rc_en_s;
    logic              rd_step_s;
    logic              wr_step_s;
    logic              reload_s;
    logic              drop_s;
    logic              err_s;

    assign start_ok_s = (state_r == IDLE) && start;

    // Next-state and per-state port controls.
    always_comb begin
        state_s   = state_r;
        rd_req_s  = 1'b0;
        wr_req_s  = 1'b0;
        wc_en_s   = 1'b0;
        rc_en_s   = 1'b0;
        rd_step_s = 1'b0;
        wr_step_s = 1'b0;
        reload_s  = 1'b0;
        case (state_r)
            IDLE: begin
                if (start) begin
                    if (xfer_words == {CNT_W{1'b0}}) begin
                        state_s = DONE;
                    end else begin
                        state_s = READ;
                    end
                end else begin
                    state_s = IDLE;
                end
            end
            READ: begin
                rd_req_s  = !full && (burst_left_r != 4'd0);
                wc_en_s   = rd_valid && !full;
                rd_step_s = rd_req_s;
                if (abort) begin
                    state_s = DRAIN;
                end else if ((burst_left_r == 4'd0) ||
                             (rd_req_s && (burst_left_r == 4'd1))) begin
                    state_s = WRITE;
                end else begin
                    state_s = READ;
                end
            end
            WRITE: begin
                wr_req_s  = !fifo_empty;
                rc_en_s   = wr_req_s && wr_ready;
                wr_step_s = rc_en_s;
                if (abort) begin
                    state_s = DRAIN;
                end else if (fifo_empty) begin
                    if (remaining_r == {CNT_W{1'b0}}) begin
                        state_s = DONE;
                    end else begin
                        state_s  = READ;
                        reload_s = 1'b1;
                    end
                end else begin
                    state_s = WRITE;
                end
            end
            DRAIN: begin
                rc_en_s = !fifo_empty;
                if (fifo_empty) begin
                    state_s = IDLE;
                end else begin
                    state_s = DRAIN;
                end
            end
            DONE: begin
                state_s = IDLE;
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // A source word that cannot be stored is dropped and flagged.
    assign drop_s = rd_valid && !((state_r == READ) && !full);
    assign err_s  = start_ok_s ? drop_s : (err_r | drop_s);

    // FSM state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Word and burst counters: loaded on start, reloaded between bursts.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            remaining_r  <= {CNT_W{1'b0}};
            burst_left_r <= 4'd0;
        end else if (start_ok_s) begin
            remaining_r  <= xfer_words;
            burst_left_r <= burst_size(32'(xfer_words), BURST_W4);
        end else if (rd_step_s) begin
            remaining_r  <= remaining_r - CNT_W'(1);
            burst_left_r <= burst_left_r - 4'd1;
        end else if (reload_s) begin
            remaining_r  <= remaining_r;
            burst_left_r <= burst_size(32'(remaining_r), BURST_W4);
        end else begin
            remaining_r  <= remaining_r;
            burst_left_r <= burst_left_r;
        end
    end

    // Status flags: sticky overflow error and the completion pulse.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_r  <= 1'b0;
            done_r <= 1'b0;
        end else begin
            err_r  <= err_s;
            done_r <= (state_r == DONE);
        end
    end

    dma_addr_gen #(.ADDR_W(ADDR_W)) u_src_addr (
        .clk       (clk),
        .rst       (rst),
        .load      (start_ok_s),
        .load_addr (src_addr),
        .inc       (rd_step_s),
        .addr      (rd_addr)
    );

    dma_addr_gen #(.ADDR_W(ADDR_W)) u_dst_addr (
        .clk       (clk),
        .rst       (rst),
        .load      (start_ok_s),
        .load_addr (dst_addr),
        .inc       (wr_step_s),
        .addr      (wr_addr)
    );

`ifdef DMA_FIFO_CTRL_IRQ_EN
    logic irq_r;
    logic irq_set_s;

    // Set on completion or a new error; a set in the same cycle as clear wins.
    assign irq_set_s = (state_r == DONE) || (err_s && !err_r);

    // Interrupt flag register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            irq_r <= 1'b0;
        end else if (irq_set_s) begin
            irq_r <= 1'b1;
        end else if (irq_clr) begin
            irq_r <= 1'b0;
        end else begin
            irq_r <= irq_r;
        end
    end

    assign irq = irq_r;
`endif

    assign rd_req = rd_req_s;
    assign wr_req = wr_req_s;
    assign wc_en  = wc_en_s;
    assign rc_en  = rc_en_s;
    assign busy   = (state_r != IDLE);
    assign done   = done_r;
    assign err    = err_r;

endmodule
